csdf_ms_scatter: RTL
====================

# csdf_ms_scatter

Cyclo-static scatter actor for the multi-flux dataflow fabric: it consumes a single token stream from an upstream show-ahead FIFO and, once per firing, writes PORTS×FLUX tokens in parallel into PORTS downstream FIFO_MS instances through their FLUX write lanes. It is the producer-side counterpart of the gather-style CSDF actor wrappers and drives the write side of FIFO_MS the way those actors drive the read side.

## Interface
- WIDTH, 8, token width in bits
- FLUX, 2, write lanes per output FIFO (tokens per port per firing)
- PORTS, 2, number of output FIFOs
- CNT_W, 16, width of the firing counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_empty  in  1  upstream FIFO empty
- in_read  out  1  pop upstream FIFO at this edge
- in_data  in  WIDTH  upstream head token, valid while in_empty=0
- out_full  in  PORTS*FLUX  per-lane full; bit index = lane*PORTS+port
- out_wr  out  PORTS*FLUX  per-lane write strobe, same indexing
- out_data  out  PORTS*FLUX*WIDTH  lane tokens; slice k = bits [k*WIDTH +: WIDTH], k = lane*PORTS+port
- fire_cnt  out  CNT_W  completed firings, wraps modulo 2^CNT_W

## Operation
- TOKENS = PORTS*FLUX; phase index k runs 0..TOKENS-1; token of phase k goes to port k%PORTS, lane k/PORTS (port index fastest).
- Staging register array stage[0..TOKENS-1], phase counter cnt (width $clog2(TOKENS), min 1).
- FSM states COLLECT, EMIT.
- COLLECT: in_read = !in_empty. On an edge with in_read=1: stage[cnt] <= in_data; if cnt==TOKENS-1 then cnt<=0, state<=EMIT, else cnt<=cnt+1.
- EMIT: in_read=0. If out_full==0 (every lane has room): out_wr = all ones, out_data = stage, and at the edge state<=COLLECT, fire_cnt<=fire_cnt+1. If any bit of out_full is set: out_wr=0, hold state and stage (all-or-nothing firing, no partial writes).
- out_data is driven from stage continuously; only meaningful when out_wr=1.
- out_wr and in_read are combinational from state, cnt-independent inputs (in_empty, out_full); never both 1 in the same cycle.
- fire_cnt wraps from 2^CNT_W-1 to 0 silently.

## Timing
- Reset (rst=0, asynchronous): state=COLLECT, cnt=0, stage all zero, fire_cnt=0; in_read and out_wr forced 0 while rst=0. First read can occur on the first edge after rst deasserts.
- Minimum firing period TOKENS+1 cycles: TOKENS read cycles plus one EMIT cycle.
- Latency: last token read at edge N -> out_wr=1 during cycle after N (if out_full==0) -> written at edge N+1.
- Upstream empty mid-collection: cnt and stage hold; resume on same phase.
- out_full toggling during EMIT: write happens in the first cycle with out_full==0; no combinational loop (out_full does not affect in_read).
- Reset asserted mid-collection or in EMIT: partial firing discarded, no write issued, fire_cnt cleared.
- TOKENS=1 (PORTS=FLUX=1): every read goes straight to EMIT; still TOKENS+1 period.

## Structure
- Shared package csdf_ms_pkg: state enum (COLLECT, EMIT), lane-index helper function lane*PORTS+port, TOKENS localparam convention.
- Single module; staging array and FSM inline. Optional sub-module csdf_ms_stage (TOKENS×WIDTH register file with indexed write) if reused by later producer actors.

## Test plan
- Default params, feed 0x11,0x22,0x33,0x44 back-to-back, out_full=0 -> in_read 4 cycles, then one cycle out_wr=4'b1111, out_data={0x44,0x33,0x22,0x11} (port0 lane0=0x11, port1 lane0=0x22, port0 lane1=0x33, port1 lane1=0x44), fire_cnt=1.
- Upstream empty for 3 cycles after second token -> cnt holds at 2, data order unchanged, write occurs 3 cycles later than unstalled case.
- out_full=4'b0100 held 5 cycles in EMIT -> out_wr=0 for 5 cycles, in_read=0, write with identical data on cycle out_full returns 0.
- rst pulsed low after 3 tokens collected -> no out_wr; next 4 tokens 0xA0..0xA3 emitted as a clean firing, fire_cnt=1.
- Continuous stream, CNT_W=4, 17 firings -> fire_cnt reads 1 after wrap, one firing every 5 cycles.
- PORTS=3, FLUX=1, tokens 1,2,3 -> out_wr=3'b111, ports 0/1/2 receive 1/2/3.

Source files
------------

// File: rtl/csdf_ms_pkg.sv
// Shared types and index helpers for the multi-flux scatter/gather actors.
// Token phase k maps to port k%PORTS, lane k/PORTS.
package csdf_ms_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } state_t;

   function automatic int tokens(input int ports, input int flux);
      return ports * flux;
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Port index runs fastest across the flat lane vector.
   function automatic int lane_idx(
      input int lane,
      input int port,
      input int ports
   );
      return lane * ports + port;
   endfunction

endpackage

// File: rtl/csdf_ms_stage.sv
// Staging register file: TOKENS entries of WIDTH bits, one indexed write per cycle.
// Cleared by the asynchronous reset so a discarded firing leaves no residue.
module csdf_ms_stage #(
   parameter int WIDTH  = 8,
   parameter int TOKENS = 4,
   parameter int IDX_W  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] q [TOKENS]
);

   logic [WIDTH-1:0] mem [TOKENS];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < TOKENS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         for (int i = 0; i < TOKENS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
               mem[i] <= wr_data;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < TOKENS; i++) begin
         q[i] = mem[i];
      end
   end

endmodule

// File: rtl/csdf_ms_scatter.sv
// Cyclo-static scatter actor: collects PORTS*FLUX tokens from one stream,
// then writes them all in one all-or-nothing firing across the FIFO_MS lanes.
module csdf_ms_scatter
   import csdf_ms_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int FLUX  = 2,
   parameter int PORTS = 2,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_empty,
   output logic                         in_read,
   input  logic [WIDTH-1:0]             in_data,
   input  logic [PORTS*FLUX-1:0]        out_full,
   output logic [PORTS*FLUX-1:0]        out_wr,
   output logic [PORTS*FLUX*WIDTH-1:0]  out_data,
   output logic [CNT_W-1:0]             fire_cnt
);

   localparam int TOKENS = tokens(PORTS, FLUX);
   localparam int IDX_W  = idx_w(TOKENS);

   state_t           state;
   state_t           state_nx;
   logic [IDX_W-1:0] cnt;
   logic             last;
   logic             take;
   logic             fire;
   logic [WIDTH-1:0] stage_q [TOKENS];

   assign last = (cnt == IDX_W'(TOKENS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= COLLECT;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         COLLECT: if (take && last) state_nx = EMIT;
         EMIT:    if (fire) state_nx = COLLECT;
         default: state_nx = COLLECT;
      endcase
   end

   // Handshakes are gated by rst so nothing moves while reset is held.
   always_comb begin
      take = 1'b0;
      fire = 1'b0;
      unique case (state)
         COLLECT: take = rst && !in_empty;
         EMIT:    fire = rst && (out_full == '0);
         default: begin
            take = 1'b0;
            fire = 1'b0;
         end
      endcase
   end

   assign in_read = take;
   assign out_wr  = {TOKENS{fire}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (take) begin
         cnt <= last ? '0 : cnt + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fire_cnt <= '0;
      end else if (fire) begin
         fire_cnt <= fire_cnt + CNT_W'(1);
      end
   end

   csdf_ms_stage #(
      .WIDTH  (WIDTH),
      .TOKENS (TOKENS),
      .IDX_W  (IDX_W)
   ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (take),
      .wr_idx  (cnt),
      .wr_data (in_data),
      .q       (stage_q)
   );

   for (genvar l = 0; l < FLUX; l++) begin : g_lane
      for (genvar p = 0; p < PORTS; p++) begin : g_port
         localparam int K = lane_idx(l, p, PORTS);
         assign out_data[K*WIDTH +: WIDTH] = stage_q[K];
      end
   end

endmodule
